byte_unstriping: RTL
====================

Name: byte_unstriping

Overview:
Receive-side counterpart of the transmit byte striper. Takes 4-lane parallel groups (lane0..lane3, 8 bits each) and re-serializes them into a single byte stream on rx_DataS, lane0 first. A 2-entry group buffer absorbs arrival jitter between group strobes and the 4-cycle serializer. Sits directly after lane reception/deskew and feeds the receive datapath.

Parameters:
INACTIVE, 8'h00, value driven on rx_DataS when no valid byte is output and on reset
BUF_DEPTH, 2, group buffer entries; fixed at 2, power of two, not to be overridden

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
enb  in  1  global enable; 0 freezes all state
rx_lane0  in  8  byte 0 of group (first out)
rx_lane1  in  8  byte 1 of group
rx_lane2  in  8  byte 2 of group
rx_lane3  in  8  byte 3 of group (last out)
rx_valid  in  1  group strobe; lanes valid when 1
rx_DataS  out  8  serialized byte
rx_ValidS  out  1  rx_DataS carries a valid byte
counter  out  2  index of byte currently on rx_DataS (0..3)
busy  out  1  serializer active or buffer non-empty
overflow  out  1  sticky: a group was dropped

Behaviour:
- Reset (rst=0 at edge): rx_DataS=INACTIVE, rx_ValidS=0, counter=0, busy=0, overflow=0, buffer empty (pointers and count 0), serializer IDLE. Reset mid-operation discards buffered and in-flight groups; no partial group is output afterwards.
- enb=0: no state change, outputs hold last values, rx_valid ignored (group lost, overflow NOT set).
- Push: rx_valid=1 and enb=1 at edge -> 32-bit group {lane3,lane2,lane1,lane0} written to buffer.
- Buffer full (count=2) and no pop same edge: group dropped, overflow<=1 (sticky until reset). Full with simultaneous pop: push accepted.
- Empty buffer and pop: never occurs; pop only when count>0.
- Serializer FSM, states IDLE, SER:
  - IDLE: buffer non-empty -> pop head into shift register, rx_DataS<=byte0, rx_ValidS<=1, counter<=0, go SER. Else rx_DataS<=INACTIVE, rx_ValidS<=0.
  - SER, counter<3: rx_DataS<=next byte, counter<=counter+1.
  - SER, counter=3: buffer non-empty -> pop, byte0 of next group, counter<=0 (wraps), stay SER (gapless). Else go IDLE, rx_ValidS<=0, rx_DataS<=INACTIVE, counter<=0.
- Latency: group pushed at edge k into empty buffer with IDLE FSM -> byte0 visible after edge k+1, bytes 1..3 after k+2..k+4.
- Push into empty buffer does not bypass; pop always reads registered storage.
- busy = (state==SER) | (count!=0), registered-equivalent (derived from registers only).
- Sustained rate: one group per 4 cycles is lossless indefinitely; faster rates overflow.

Optional Feature:
BYTE_UNSTRIPING_DROP_CNT_EN
- Defined: adds output drop_cnt [7:0], reset 0, increments on each dropped group, saturates at 8'hFF; overflow unchanged.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package: INACTIVE constant, lane count (4), lane width (8), FSM state encoding (IDLE=1'b0, SER=1'b1), group word typedef (32 bits).
- One sub-module: byte_unstriping_buf (2-entry synchronous group FIFO with push/pop/full/empty/count); FSM and shift register stay in top.

Test Plan:
- Reset: hold rst=0 3 cycles with rx_valid=1 -> rx_DataS=8'h00, rx_ValidS=0, busy=0, overflow=0 throughout.
- Single group 11,22,33,44 (lane0..3) at edge k -> rx_DataS 11,22,33,44 after edges k+1..k+4 with counter 0..3, then INACTIVE/ValidS=0.
- Groups every 4 cycles (AA..A3, B0..B3, C0..C3) -> gapless 12-byte stream, rx_ValidS constantly 1, overflow=0.
- rx_valid 4 consecutive cycles (groups 0..3) -> groups 0,1,2 output in order, group 3 dropped, overflow=1 and stays 1; with BYTE_UNSTRIPING_DROP_CNT_EN drop_cnt=1.
- enb=0 for 3 cycles while outputting byte1 -> rx_DataS/counter frozen, resumes with byte2 after enb=1; rx_valid during enb=0 not captured.
- rst=0 while counter=2 with one group buffered -> next cycle idle, no remaining bytes ever output.

Source files
------------

// File: rtl/byte_unstriping_pkg.sv
// Shared types and constants for the byte unstriper: lane geometry, group word,
// idle output value and serializer state encoding.
package byte_unstriping_pkg;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned GROUP_W   = NUM_LANES * LANE_W;
  localparam int unsigned BUF_DEPTH = 2;

  typedef logic [LANE_W-1:0]  lane_t;
  typedef logic [GROUP_W-1:0] group_t;

  localparam lane_t INACTIVE_BYTE = 8'h00;

  typedef enum logic {
    IDLE = 1'b0,
    SER  = 1'b1
  } ser_state_t;
endpackage

// File: rtl/byte_unstriping_buf.sv
// Two-entry synchronous group FIFO; dout always reads registered storage at the
// head, so a push into an empty buffer is visible to pop only on the next edge.
module byte_unstriping_buf
  import byte_unstriping_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       push,
  input  logic       pop,
  input  group_t     din,
  output group_t     dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);
  group_t mem [BUF_DEPTH];
  logic   wr_ptr;
  logic   rd_ptr;
  logic   push_ok;
  logic   pop_ok;

  assign full    = (count == 2'(BUF_DEPTH));
  assign empty   = (count == 2'd0);
  assign pop_ok  = pop && !empty;
  // A full buffer still accepts a push when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (enb) begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end
endmodule

// File: rtl/byte_unstriping.sv
// Re-serializes 4-lane byte groups into one byte stream, lane0 first, through a
// 2-group buffer. Optional drop counter: define BYTE_UNSTRIPING_DROP_CNT_EN.
module byte_unstriping
  import byte_unstriping_pkg::*;
#(
  parameter lane_t INACTIVE = INACTIVE_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [7:0] rx_lane0,
  input  logic [7:0] rx_lane1,
  input  logic [7:0] rx_lane2,
  input  logic [7:0] rx_lane3,
  input  logic       rx_valid,
  output logic [7:0] rx_DataS,
  output logic       rx_ValidS,
  output logic [1:0] counter,
  output logic       busy,
`ifdef BYTE_UNSTRIPING_DROP_CNT_EN
  output logic [7:0] drop_cnt,
`endif
  output logic       overflow
);
  ser_state_t state, state_nxt;
  group_t     shreg, shreg_nxt;
  group_t     buf_dout;
  lane_t      data_nxt;
  logic       valid_nxt;
  logic [1:0] cnt_nxt;
  logic       pop;
  logic       buf_full;
  logic       buf_empty;
  logic [1:0] buf_count;
  logic       drop;

  byte_unstriping_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .enb   (enb),
    .push  (rx_valid),
    .pop   (pop),
    .din   ({rx_lane3, rx_lane2, rx_lane1, rx_lane0}),
    .dout  (buf_dout),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign drop = rx_valid && buf_full && !pop;
  assign busy = (state == SER) || (buf_count != 2'd0);

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    data_nxt  = rx_DataS;
    valid_nxt = rx_ValidS;
    cnt_nxt   = counter;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!buf_empty) begin
          pop       = 1'b1;
          shreg_nxt = buf_dout;
          data_nxt  = buf_dout[LANE_W-1:0];
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = SER;
        end else begin
          data_nxt  = INACTIVE;
          valid_nxt = 1'b0;
        end
      end
      SER: begin
        if (counter != 2'd3) begin
          // Shift register keeps the byte on the output in its low lane.
          shreg_nxt = shreg >> LANE_W;
          data_nxt  = shreg[2*LANE_W-1:LANE_W];
          cnt_nxt   = counter + 2'd1;
        end else if (!buf_empty) begin
          pop       = 1'b1;
          shreg_nxt = buf_dout;
          data_nxt  = buf_dout[LANE_W-1:0];
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
          data_nxt  = INACTIVE;
          valid_nxt = 1'b0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      rx_DataS  <= INACTIVE;
      rx_ValidS <= 1'b0;
      counter   <= '0;
      overflow  <= 1'b0;
    end else if (enb) begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      rx_DataS  <= data_nxt;
      rx_ValidS <= valid_nxt;
      counter   <= cnt_nxt;
      overflow  <= overflow || drop;
    end
  end

`ifdef BYTE_UNSTRIPING_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (enb && drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif
endmodule
